// File: rtl/simple_bus_arbiter_if.sv
// Bundle of the arbiter's bus-facing signals.
//   req        per-master level request
//   start      bus snoop: start strobe (upper-address cycle)
//   read       bus snoop: read flag, valid in the lower-address cycle
//   dataValid  bus snoop: data-phase completion strobe
//   gnt        one-hot grant
//   owner      index of the granted master, valid while busy
//   busy       arbiter is not idle
//   timeout    one-cycle pulse when an unused grant is revoked
//   proto_err  one-cycle pulse on an unexpected start
// The slave modport is the arbiter's view; the master modport is the
// view of whatever drives requests and snooped bus activity.
interface simple_bus_arbiter_if #(
    parameter int N_MASTERS = 4
);
    logic [N_MASTERS-1:0]         req;
    logic                         start;
    logic                         read;
    logic                         dataValid;
    logic [N_MASTERS-1:0]         gnt;
    logic [$clog2(N_MASTERS)-1:0] owner;
    logic                         busy;
    logic                         timeout;
    logic                         proto_err;

    modport slave (
        input  req, start, read, dataValid,
        output gnt, owner, busy, timeout, proto_err
    );

    modport master (
        output req, start, read, dataValid,
        input  gnt, owner, busy, timeout, proto_err
    );
endinterface

// File: rtl/simple_bus_arbiter.sv
// Round-robin arbiter and transaction tracker for the multiplexed simple bus.
// Grants the bus to one master at a time, follows the granted transaction
// through its address and data phases by snooping start/read/dataValid, and
// releases the grant when the data phase completes. A grant left unused for
// GRANT_TIMEOUT cycles is revoked.
// Ports:
//   clock  bus clock, all state updates on the rising edge
//   reset  asynchronous, active-high reset
//   bus    simple_bus_arbiter_if.slave (req/start/read/dataValid in,
//          gnt/owner/busy/timeout/proto_err out, all outputs registered)
module simple_bus_arbiter #(
    parameter int N_MASTERS     = 4,
    parameter int GRANT_TIMEOUT = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    simple_bus_arbiter_if.slave   bus
);

    localparam int OW = $clog2(N_MASTERS);
    localparam int CW = $clog2(GRANT_TIMEOUT);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GRANTED = 3'd1;
    localparam logic [2:0] S_ADDR    = 3'd2;
    localparam logic [2:0] S_RDATA   = 3'd3;
    localparam logic [2:0] S_WDATA   = 3'd4;

    localparam logic [CW-1:0]        CNT_LAST = CW'(GRANT_TIMEOUT - 1);
    localparam logic [OW-1:0]        LAST_RST = OW'(N_MASTERS - 1);
    localparam logic [N_MASTERS-1:0] ONE_HOT0 = {{(N_MASTERS-1){1'b0}}, 1'b1};

    // Round-robin search: first set request after 'last', wrapping modulo
    // N_MASTERS. Returns {found, index}.
    function automatic logic [OW:0] pick_next(input logic [N_MASTERS-1:0] r,
                                               input logic [OW-1:0]        last);
        logic          found;
        logic [OW-1:0] idx;
        logic [OW-1:0] cand;
        found = 1'b0;
        idx   = {OW{1'b0}};
        for (int k = 1; k <= N_MASTERS; k++) begin
            cand = OW'((int'(last) + k) % N_MASTERS);
            if (!found && r[cand]) begin
                found = 1'b1;
                idx   = cand;
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    logic [2:0]           state_r;
    logic [N_MASTERS-1:0] gnt_r;
    logic [OW-1:0]        owner_r;
    logic [OW-1:0]        last_r;
    logic [CW-1:0]        cnt_r;
    logic                 busy_r;
    logic                 timeout_r;
    logic                 proto_err_r;

    logic [2:0]           state_s;
    logic [N_MASTERS-1:0] gnt_s;
    logic [OW-1:0]        owner_s;
    logic [OW-1:0]        last_s;
    logic [CW-1:0]        cnt_s;
    logic                 timeout_s;
    logic                 proto_err_s;
    logic [OW:0]          pick_s;

    // Next-state logic: arbitration, transaction tracking and pulse generation.
    always_comb begin
        state_s     = state_r;
        gnt_s       = gnt_r;
        owner_s     = owner_r;
        last_s      = last_r;
        cnt_s       = cnt_r;
        timeout_s   = 1'b0;
        proto_err_s = 1'b0;
        pick_s      = pick_next(bus.req, last_r);

        case (state_r)
            S_IDLE: begin
                // A start with nobody granted is a protocol violation; the
                // arbiter holds still for that cycle rather than granting
                // into a bus that someone is already driving.
                if (bus.start) begin
                    proto_err_s = 1'b1;
                    gnt_s       = {N_MASTERS{1'b0}};
                end else if (pick_s[OW]) begin
                    state_s = S_GRANTED;
                    gnt_s   = ONE_HOT0 << pick_s[OW-1:0];
                    owner_s = pick_s[OW-1:0];
                    last_s  = pick_s[OW-1:0];
                    cnt_s   = {CW{1'b0}};
                end else begin
                    gnt_s = {N_MASTERS{1'b0}};
                end
            end
            S_GRANTED: begin
                if (bus.start) begin
                    state_s = S_ADDR;
                end else if (!bus.req[owner_r]) begin
                    state_s = S_IDLE;
                    gnt_s   = {N_MASTERS{1'b0}};
                end else if (cnt_r == CNT_LAST) begin
                    state_s   = S_IDLE;
                    gnt_s     = {N_MASTERS{1'b0}};
                    timeout_s = 1'b1;
                end else begin
                    // Never reaches CNT_LAST+1, so the counter cannot wrap.
                    cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            S_ADDR: begin
                if (bus.start) begin
                    proto_err_s = 1'b1;
                end else begin
                    proto_err_s = 1'b0;
                end
                state_s = bus.read ? S_RDATA : S_WDATA;
            end
            S_RDATA, S_WDATA: begin
                // A stray start is flagged but never aborts the transfer.
                if (bus.start) begin
                    proto_err_s = 1'b1;
                end else begin
                    proto_err_s = 1'b0;
                end
                if (bus.dataValid) begin
                    state_s = S_IDLE;
                    gnt_s   = {N_MASTERS{1'b0}};
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = S_IDLE;
                gnt_s   = {N_MASTERS{1'b0}};
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= S_IDLE;
            gnt_r       <= {N_MASTERS{1'b0}};
            owner_r     <= {OW{1'b0}};
            last_r      <= LAST_RST;
            cnt_r       <= {CW{1'b0}};
            busy_r      <= 1'b0;
            timeout_r   <= 1'b0;
            proto_err_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            gnt_r       <= gnt_s;
            owner_r     <= owner_s;
            last_r      <= last_s;
            cnt_r       <= cnt_s;
            busy_r      <= (state_s != S_IDLE);
            timeout_r   <= timeout_s;
            proto_err_r <= proto_err_s;
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.owner     = owner_r;
    assign bus.busy      = busy_r;
    assign bus.timeout   = timeout_r;
    assign bus.proto_err = proto_err_r;

endmodule

// File: tb/tb_simple_bus_arbiter.sv
// Scoreboard bench for simple_bus_arbiter. A transaction-level reference
// model advances on every rising edge and queues the outputs it expects;
// a monitor on the falling edge pops and compares against the DUT.
module tb_simple_bus_arbiter;

    localparam int N  = 4;
    localparam int GT = 8;

    localparam int P_IDLE = 0;
    localparam int P_WAIT = 1;   // granted, waiting for start
    localparam int P_ADDR = 2;   // lower-address cycle
    localparam int P_DATA = 3;   // waiting for dataValid

    typedef struct {
        logic [N-1:0] gnt;
        int           owner;
        logic         busy;
        logic         to;
        logic         pe;
    } exp_t;

    logic clock;
    logic reset;

    simple_bus_arbiter_if #(.N_MASTERS(N)) bus ();

    simple_bus_arbiter #(.N_MASTERS(N), .GRANT_TIMEOUT(GT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    // reference model state
    int   m_phase;
    int   m_owner;
    int   m_last;
    int   m_wait;
    logic m_to;
    logic m_pe;

    function automatic void model_reset();
        m_phase = P_IDLE;
        m_owner = 0;
        m_last  = N - 1;
        m_wait  = 0;
        m_to    = 1'b0;
        m_pe    = 1'b0;
    endfunction

    function automatic void model_step(input logic [N-1:0] r, input logic s,
                                       input logic rd, input logic dv);
        m_to = 1'b0;
        m_pe = 1'b0;
        if (m_phase == P_IDLE) begin
            if (s) m_pe = 1'b1;
            else begin
                for (int k = 1; k <= N; k++) begin
                    if (m_phase == P_IDLE && r[(m_last + k) % N]) begin
                        m_owner = (m_last + k) % N;
                        m_last  = m_owner;
                        m_wait  = 0;
                        m_phase = P_WAIT;
                    end
                end
            end
        end else if (m_phase == P_WAIT) begin
            if (s) m_phase = P_ADDR;
            else if (!r[m_owner]) m_phase = P_IDLE;
            else if (m_wait + 1 == GT) begin
                m_phase = P_IDLE;
                m_to    = 1'b1;
            end else m_wait = m_wait + 1;
        end else if (m_phase == P_ADDR) begin
            m_pe    = s;
            m_phase = P_DATA;
            if (rd) m_phase = P_DATA;
        end else begin
            m_pe = s;
            if (dv) m_phase = P_IDLE;
        end
    endfunction

    function automatic void push_expect();
        exp_t e;
        e.busy  = (m_phase != P_IDLE);
        e.gnt   = e.busy ? (N'(1) << m_owner) : '0;
        e.owner = m_owner;
        e.to    = m_to;
        e.pe    = m_pe;
        exp_q.push_back(e);
    endfunction

    // Model advances on each rising edge using the inputs held that cycle.
    always @(posedge clock) begin
        if (reset) model_reset();
        else model_step(bus.req, bus.start, bus.read, bus.dataValid);
        push_expect();
    end

    // Monitor: compare DUT outputs with the oldest expectation.
    always @(negedge clock) begin
        exp_t e;
        logic ok;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            ok = (bus.gnt === e.gnt) && (bus.busy === e.busy) &&
                 (bus.timeout === e.to) && (bus.proto_err === e.pe) &&
                 (!e.busy || int'(bus.owner) == e.owner);
            checks = checks + 1;
            if (ok) passed = passed + 1;
            else $display("FAIL outputs @%0t: got gnt=%b owner=%0d busy=%b timeout=%b proto_err=%b, want gnt=%b owner=%0d busy=%b timeout=%b proto_err=%b",
                          $time, bus.gnt, bus.owner, bus.busy, bus.timeout, bus.proto_err,
                          e.gnt, e.owner, e.busy, e.to, e.pe);
        end
    end

    // Drive one cycle of bus inputs, then advance past the next rising edge.
    task automatic drv(input logic [N-1:0] r, input logic s, input logic rd, input logic dv);
        bus.req       = r;
        bus.start     = s;
        bus.read      = rd;
        bus.dataValid = dv;
        @(posedge clock);
        #1;
    endtask

    // Hold a request pattern until a grant arrives, then run one transfer.
    task automatic txn(input logic [N-1:0] r, input logic rd, input int extra, input logic stray);
        int n;
        n = 0;
        while (m_phase != P_WAIT && n < 20) begin
            drv(r, 1'b0, 1'b0, 1'b0);
            n++;
        end
        drv(r, 1'b1, 1'b0, 1'b0);
        drv(r, 1'b0, rd, 1'b0);
        if (stray) drv(r, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < extra; i++) drv(r, 1'b0, 1'b0, 1'b0);
        drv(r, 1'b0, 1'b0, 1'b1);
    endtask

    // Assert reset between edges; the already-queued expectation for this
    // cycle is replaced by the reset state, which must appear at once.
    task automatic async_reset();
        exp_t junk;
        reset = 1'b1;
        junk  = exp_q.pop_back();
        model_reset();
        push_expect();
    endtask

    logic [N-1:0] cur_req;
    logic [N-1:0] r;
    logic         s, rd, dv, lazy;
    int           to_cnt;
    logic         to_gnt_ok;

    initial begin
        model_reset();
        reset = 1'b1;
        bus.req = '0; bus.start = 1'b0; bus.read = 1'b0; bus.dataValid = 1'b0;
        lazy = 1'b0;
        drv(4'b0000, 1'b0, 1'b0, 1'b0);
        drv(4'b0000, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // single read from master 0
        drv(4'b0001, 1'b0, 1'b0, 1'b0);
        txn(4'b0001, 1'b1, 1, 1'b0);
        drv(4'b0000, 1'b0, 1'b0, 1'b0);
        drv(4'b0000, 1'b0, 1'b0, 1'b0);

        // round robin with all masters requesting, minimum-length writes
        for (int i = 0; i < 5; i++) txn(4'b1111, 1'b0, 0, 1'b0);
        drv(4'b0000, 1'b0, 1'b0, 1'b0);
        drv(4'b0000, 1'b0, 1'b0, 1'b0);

        // timeout: master 2 holds req without ever starting
        to_cnt    = 0;
        to_gnt_ok = 1'b1;
        for (int i = 0; i < 22; i++) begin
            drv(4'b0100, 1'b0, 1'b0, 1'b0);
            if (bus.timeout === 1'b1) begin
                to_cnt = to_cnt + 1;
                if (bus.gnt !== 4'b0000) to_gnt_ok = 1'b0;
            end
        end
        checks = checks + 1;
        if (to_cnt == 2 && to_gnt_ok) passed = passed + 1;
        else $display("FAIL expired wait @%0t: got %0d timeout pulses (gnt low on pulse=%b), want 2 pulses with gnt=0000",
                      $time, to_cnt, to_gnt_ok);
        drv(4'b0000, 1'b0, 1'b0, 1'b0);
        drv(4'b0000, 1'b0, 1'b0, 1'b0);

        // withdraw before start
        drv(4'b0010, 1'b0, 1'b0, 1'b0);
        drv(4'b0000, 1'b0, 1'b0, 1'b0);
        drv(4'b0000, 1'b0, 1'b0, 1'b0);
        drv(4'b0000, 1'b0, 1'b0, 1'b0);

        // protocol errors: start while idle, start during a read data phase
        drv(4'b0000, 1'b1, 1'b0, 1'b0);
        drv(4'b0000, 1'b0, 1'b0, 1'b0);
        drv(4'b0000, 1'b0, 1'b0, 1'b0);
        txn(4'b0001, 1'b1, 1, 1'b1);
        drv(4'b0000, 1'b0, 1'b0, 1'b0);
        drv(4'b0000, 1'b0, 1'b0, 1'b0);

        // reset in the middle of a write data phase
        drv(4'b1111, 1'b0, 1'b0, 1'b0);
        drv(4'b1111, 1'b1, 1'b0, 1'b0);
        drv(4'b1111, 1'b0, 1'b0, 1'b0);
        async_reset();
        #1;
        checks = checks + 1;
        if (bus.gnt === 4'b0000 && bus.busy === 1'b0 && bus.timeout === 1'b0 &&
            bus.proto_err === 1'b0 && bus.owner === 2'd0) passed = passed + 1;
        else $display("FAIL reset state @%0t: got gnt=%b owner=%0d busy=%b timeout=%b proto_err=%b, want all zero",
                      $time, bus.gnt, bus.owner, bus.busy, bus.timeout, bus.proto_err);
        drv(4'b1111, 1'b0, 1'b0, 1'b0);
        drv(4'b1111, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        txn(4'b1111, 1'b0, 2, 1'b0);
        drv(4'b0000, 1'b0, 1'b0, 1'b0);

        // randomized traffic
        cur_req = '0;
        for (int c = 0; c < 3000; c++) begin
            r = cur_req;
            for (int b = 0; b < N; b++) if ($urandom % 8 == 0) r[b] = ~r[b];
            s  = 1'b0;
            rd = 1'($urandom % 2);
            dv = 1'b0;
            case (m_phase)
                P_IDLE: if ($urandom % 16 == 0) s = 1'b1;
                P_WAIT: begin
                    if (m_wait == 0) lazy = ($urandom % 4 == 0);
                    if (!lazy && $urandom % 3 == 0) s = 1'b1;
                end
                P_ADDR: s = 1'b0;
                default: begin
                    dv = ($urandom % 3 == 0);
                    if (!dv && $urandom % 12 == 0) s = 1'b1;
                end
            endcase
            cur_req = r;
            drv(r, s, rd, dv);
        end

        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
